sat_cmd_sequencer: RTL and testbench
====================================

// Module: sat_cmd_sequencer
// PURPOSE
//  Upstream front-end for the SAT solver core. Parses a host byte stream (valid/ready) into solver commands.
//  Drives the core's cmd/bus_a/bus_b/bus_c as single-cycle strobes.
//  Tracks the clause count. After a walk, waits for sat/unsat and reports the result, a timeout, or a protocol error.
// PARAMETERS
//  NUM_VARS      128     valid variable indices are 0..NUM_VARS-1 (max 128)
//  MAX_CLAUSES   256     clause capacity of the core; CW = $clog2(MAX_CLAUSES+1)
//  WALK_TIMEOUT  65535   cycles to wait for sat/unsat after issuing WALK
//  NOP_CMD       8'hFF   cmd value driven whenever no command is issued
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous active-high reset
//  in_data       in   8    host stream byte
//  in_valid      in   1    in_data valid
//  in_ready      out  1    byte accepted when in_valid & in_ready
//  cmd           out  8    solver command strobe (NOP_CMD when idle)
//  bus_a/b/c     out  8    clause literals; each bit7 = negated, [6:0] = var
//  sat           in   1    solver reports satisfiable
//  unsat         in   1    solver reports unsatisfiable
//  done          out  1    1-cycle pulse: walk finished (result or timeout)
//  result_sat    out  1    held from done until the next WALK is issued
//  result_unsat  out  1    held from done until the next WALK is issued
//  timeout       out  1    held from done until the next WALK is issued
//  err           out  1    sticky error; cleared only by rst
//  err_code      out  2    1 = bad opcode, 2 = var >= NUM_VARS, 3 = clause overflow or sat&unsat together
//  clause_count  out  CW   clauses issued since the last RST_MODEL
// BEHAVIOUR
//  Reset values
//   - cmd = NOP_CMD; bus_a/b/c = 0; all flags = 0; clause_count = 0.
//   - state = IDLE; in_ready = 1.
//  All outputs are registered.
//  States: IDLE, LIT0, LIT1, LIT2, ISSUE, WALK_WAIT, ERR.
//  in_ready = 1 in IDLE/LIT0/LIT1/LIT2; 0 in ISSUE/WALK_WAIT/ERR. A byte not accepted is never consumed.
//  IDLE accepts an opcode byte:
//   - 0x00, 0x01, 0x03, 0x04 -> ISSUE.
//   - 0x02 with clause_count < MAX_CLAUSES -> LIT0.
//   - 0x02 with clause_count == MAX_CLAUSES -> ERR, code 3.
//   - Any other byte -> ERR, code 1.
//  LIT0/1/2 each accept one literal:
//   - The byte is latched into the bus_a/b/c shadow register respectively.
//   - If byte[6:0] >= NUM_VARS -> ERR, code 2; no command is issued.
//   - LIT2 accept -> ISSUE.
//  ISSUE (exactly 1 cycle):
//   - cmd = opcode; bus_a/b/c = latched literals on INS_CLAUSE, else 0.
//   - The next cycle returns cmd to NOP_CMD; bus values hold until the next ISSUE.
//   - Opcode 0x00 clears clause_count in the same cycle; 0x02 increments it.
//   - Opcode 0x04 clears result_sat/result_unsat/timeout, zeroes the wait counter, and goes to WALK_WAIT; all others go to IDLE.
//  Latency: last byte accepted at edge N -> cmd valid during cycle N+1 -> in_ready high again in cycle N+2.
//  WALK_WAIT, counter increments each cycle (sat/unsat sampled every cycle, including the first):
//   - sat & ~unsat -> result_sat = 1, done pulse, IDLE.
//   - unsat & ~sat -> result_unsat = 1, done pulse, IDLE.
//   - sat & unsat -> ERR, code 3; no done pulse.
//   - Counter reaches WALK_TIMEOUT with neither asserted -> timeout = 1, done pulse, IDLE.
//   - A result arriving in the same cycle as the timeout wins over the timeout.
//   - sat/unsat outside WALK_WAIT are ignored.
//  ERR:
//   - Absorbing state; in_ready = 0, cmd = NOP_CMD; err/err_code hold until rst.
//   - Only the first error's code is recorded.
//  rst mid-operation: returns to IDLE and reset values, discarding any partial clause or pending walk.
// TESTING
//  T1 bytes 02 05 86 7F -> one cycle cmd=02, bus_a=05, bus_b=86, bus_c=7F; clause_count=1; cmd=FF next cycle.
//  T2 bytes 04; hold sat=1 from 10 cycles after cmd=04 -> done pulse once; result_sat=1, timeout=0; in_ready=1.
//  T3 WALK_TIMEOUT=20; bytes 04, sat/unsat held 0 -> done after 20 cycles; timeout=1, result_sat=result_unsat=0.
//  T4 bytes 02 05 C0 01 with NUM_VARS=64 -> err=1, err_code=2; no cmd=02 issued; in_ready=0 until rst.
//  T5 MAX_CLAUSES=2: three clauses -> third 02 gives err_code=3; bytes 00 after rst -> cmd=00, clause_count=0.
//  T6 bytes 09 -> err_code=1; rst asserted after 02 05 (partial clause) -> IDLE; next 02 01 02 03 issues cleanly.

Source files
------------

// File: rtl/sat_cmd_sequencer.sv
// sat_cmd_sequencer: host byte-stream front-end for the SAT solver core.
// Parses opcode/literal bytes into single-cycle command strobes with clause
// literals, tracks the clause count, and supervises the walk handshake
// (sat/unsat result, timeout, or protocol error).
module sat_cmd_sequencer #(
    parameter int          NUM_VARS     = 128,
    parameter int          MAX_CLAUSES  = 256,
    parameter int          WALK_TIMEOUT = 65535,
    parameter logic [7:0]  NOP_CMD      = 8'hFF,
    localparam int         CW           = $clog2(MAX_CLAUSES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    cmd,
    output logic [7:0]    bus_a,
    output logic [7:0]    bus_b,
    output logic [7:0]    bus_c,
    input  logic          sat,
    input  logic          unsat,
    output logic          done,
    output logic          result_sat,
    output logic          result_unsat,
    output logic          timeout,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [CW-1:0] clause_count
);

    localparam int TW = (WALK_TIMEOUT > 1) ? $clog2(WALK_TIMEOUT + 1) : 1;

    localparam logic [7:0] OP_RST_MODEL  = 8'h00;
    localparam logic [7:0] OP_AUX_1      = 8'h01;
    localparam logic [7:0] OP_INS_CLAUSE = 8'h02;
    localparam logic [7:0] OP_AUX_3      = 8'h03;
    localparam logic [7:0] OP_WALK       = 8'h04;

    localparam logic [1:0] ERR_OPCODE    = 2'd1;
    localparam logic [1:0] ERR_VAR       = 2'd2;
    localparam logic [1:0] ERR_CAPACITY  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LIT0      = 3'd1,
        S_LIT1      = 3'd2,
        S_LIT2      = 3'd3,
        S_ISSUE     = 3'd4,
        S_WALK_WAIT = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [7:0]    lit_a_q, lit_a_d;
    logic [7:0]    lit_b_q, lit_b_d;
    logic          in_ready_q, in_ready_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    bus_a_q, bus_a_d;
    logic [7:0]    bus_b_q, bus_b_d;
    logic [7:0]    bus_c_q, bus_c_d;
    logic          done_q, done_d;
    logic          result_sat_q, result_sat_d;
    logic          result_unsat_q, result_unsat_d;
    logic          timeout_q, timeout_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [CW-1:0] clause_count_q, clause_count_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    logic          accept_s;
    logic          var_bad_s;
    logic          cc_full_s;
    logic          timeout_hit_s;
    logic          issue_s;
    logic [7:0]    issue_op_s;
    logic          fail_s;
    logic [1:0]    fail_code_s;

    // Next-state and next-output computation for the parser / walk supervisor.
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        lit_a_d        = lit_a_q;
        lit_b_d        = lit_b_q;
        cmd_d          = NOP_CMD;
        bus_a_d        = bus_a_q;
        bus_b_d        = bus_b_q;
        bus_c_d        = bus_c_q;
        done_d         = 1'b0;
        result_sat_d   = result_sat_q;
        result_unsat_d = result_unsat_q;
        timeout_d      = timeout_q;
        err_d          = err_q;
        err_code_d     = err_code_q;
        clause_count_d = clause_count_q;
        wait_cnt_d     = wait_cnt_q;
        in_ready_d     = 1'b0;

        accept_s      = in_valid & in_ready_q;
        var_bad_s     = (32'(in_data[6:0]) >= 32'(NUM_VARS));
        cc_full_s     = (clause_count_q >= CW'(MAX_CLAUSES));
        timeout_hit_s = (wait_cnt_q == TW'(WALK_TIMEOUT - 1));
        issue_s       = 1'b0;
        issue_op_s    = NOP_CMD;
        fail_s        = 1'b0;
        fail_code_s   = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (in_data)
                        OP_RST_MODEL, OP_AUX_1, OP_AUX_3, OP_WALK: begin
                            issue_s    = 1'b1;
                            issue_op_s = in_data;
                        end
                        OP_INS_CLAUSE: begin
                            if (cc_full_s) begin
                                fail_s      = 1'b1;
                                fail_code_s = ERR_CAPACITY;
                            end else begin
                                opcode_d = in_data;
                                state_d  = S_LIT0;
                            end
                        end
                        default: begin
                            fail_s      = 1'b1;
                            fail_code_s = ERR_OPCODE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LIT0: begin
                if (accept_s) begin
                    lit_a_d = in_data;
                    if (var_bad_s) begin
                        fail_s      = 1'b1;
                        fail_code_s = ERR_VAR;
                    end else begin
                        state_d = S_LIT1;
                    end
                end else begin
                    state_d = S_LIT0;
                end
            end
            S_LIT1: begin
                if (accept_s) begin
                    lit_b_d = in_data;
                    if (var_bad_s) begin
                        fail_s      = 1'b1;
                        fail_code_s = ERR_VAR;
                    end else begin
                        state_d = S_LIT2;
                    end
                end else begin
                    state_d = S_LIT1;
                end
            end
            S_LIT2: begin
                if (accept_s) begin
                    if (var_bad_s) begin
                        fail_s      = 1'b1;
                        fail_code_s = ERR_VAR;
                    end else begin
                        issue_s    = 1'b1;
                        issue_op_s = OP_INS_CLAUSE;
                    end
                end else begin
                    state_d = S_LIT2;
                end
            end
            S_ISSUE: begin
                // The strobe is visible this cycle; decide where to go next.
                if (opcode_q == OP_WALK) begin
                    wait_cnt_d = {TW{1'b0}};
                    state_d    = S_WALK_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WALK_WAIT: begin
                // A result seen on the timeout cycle still beats the timeout.
                if (sat & ~unsat) begin
                    result_sat_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else if (unsat & ~sat) begin
                    result_unsat_d = 1'b1;
                    done_d         = 1'b1;
                    state_d        = S_IDLE;
                end else if (sat & unsat) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_CAPACITY;
                end else if (timeout_hit_s) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fail_s) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            if (!err_q) begin
                err_code_d = fail_code_s;
            end else begin
                err_code_d = err_code_q;
            end
        end else begin
            err_d = err_q;
        end

        if (issue_s) begin
            cmd_d    = issue_op_s;
            opcode_d = issue_op_s;
            state_d  = S_ISSUE;
            if (issue_op_s == OP_INS_CLAUSE) begin
                bus_a_d        = lit_a_q;
                bus_b_d        = lit_b_q;
                bus_c_d        = in_data;
                clause_count_d = clause_count_q + CW'(1);
            end else begin
                bus_a_d = 8'h00;
                bus_b_d = 8'h00;
                bus_c_d = 8'h00;
            end
            if (issue_op_s == OP_RST_MODEL) begin
                clause_count_d = {CW{1'b0}};
            end else begin
                clause_count_d = clause_count_d;
            end
            if (issue_op_s == OP_WALK) begin
                result_sat_d   = 1'b0;
                result_unsat_d = 1'b0;
                timeout_d      = 1'b0;
                wait_cnt_d     = {TW{1'b0}};
            end else begin
                timeout_d = timeout_d;
            end
        end else begin
            cmd_d = cmd_d;
        end

        case (state_d)
            S_IDLE, S_LIT0, S_LIT1, S_LIT2: in_ready_d = 1'b1;
            default:                        in_ready_d = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            opcode_q       <= 8'h00;
            lit_a_q        <= 8'h00;
            lit_b_q        <= 8'h00;
            in_ready_q     <= 1'b1;
            cmd_q          <= NOP_CMD;
            bus_a_q        <= 8'h00;
            bus_b_q        <= 8'h00;
            bus_c_q        <= 8'h00;
            done_q         <= 1'b0;
            result_sat_q   <= 1'b0;
            result_unsat_q <= 1'b0;
            timeout_q      <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= 2'd0;
            clause_count_q <= {CW{1'b0}};
            wait_cnt_q     <= {TW{1'b0}};
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            lit_a_q        <= lit_a_d;
            lit_b_q        <= lit_b_d;
            in_ready_q     <= in_ready_d;
            cmd_q          <= cmd_d;
            bus_a_q        <= bus_a_d;
            bus_b_q        <= bus_b_d;
            bus_c_q        <= bus_c_d;
            done_q         <= done_d;
            result_sat_q   <= result_sat_d;
            result_unsat_q <= result_unsat_d;
            timeout_q      <= timeout_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            clause_count_q <= clause_count_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign cmd          = cmd_q;
    assign bus_a        = bus_a_q;
    assign bus_b        = bus_b_q;
    assign bus_c        = bus_c_q;
    assign done         = done_q;
    assign result_sat   = result_sat_q;
    assign result_unsat = result_unsat_q;
    assign timeout      = timeout_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign clause_count = clause_count_q;

endmodule

// File: tb/tb_sat_cmd_sequencer.sv
// Bench for sat_cmd_sequencer: two instances (wide/default-ish and a small
// NUM_VARS=64 / MAX_CLAUSES=2 / WALK_TIMEOUT=20 one), each followed by a
// transaction-level model compared every cycle, plus directed literal checks.
module tb_sat_cmd_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s      [2];
    logic [7:0] in_data_s  [2];
    logic       in_valid_s [2];
    logic       sat_s      [2];
    logic       unsat_s    [2];

    logic       rdy_0, done_0, rs_0, ru_0, to_0, err_0;
    logic [7:0] cmd_0, a_0, b_0, c_0;
    logic [1:0] code_0;
    logic [8:0] cc_0;
    logic       rdy_1, done_1, rs_1, ru_1, to_1, err_1;
    logic [7:0] cmd_1, a_1, b_1, c_1;
    logic [1:0] code_1;
    logic [1:0] cc_1;

    sat_cmd_sequencer #(.NUM_VARS(128), .MAX_CLAUSES(256), .WALK_TIMEOUT(40), .NOP_CMD(8'hFF)) u_big (
        .clk(clk), .rst(rst_s[0]), .in_data(in_data_s[0]), .in_valid(in_valid_s[0]), .in_ready(rdy_0),
        .cmd(cmd_0), .bus_a(a_0), .bus_b(b_0), .bus_c(c_0), .sat(sat_s[0]), .unsat(unsat_s[0]),
        .done(done_0), .result_sat(rs_0), .result_unsat(ru_0), .timeout(to_0), .err(err_0),
        .err_code(code_0), .clause_count(cc_0));

    sat_cmd_sequencer #(.NUM_VARS(64), .MAX_CLAUSES(2), .WALK_TIMEOUT(20), .NOP_CMD(8'hFF)) u_small (
        .clk(clk), .rst(rst_s[1]), .in_data(in_data_s[1]), .in_valid(in_valid_s[1]), .in_ready(rdy_1),
        .cmd(cmd_1), .bus_a(a_1), .bus_b(b_1), .bus_c(c_1), .sat(sat_s[1]), .unsat(unsat_s[1]),
        .done(done_1), .result_sat(rs_1), .result_unsat(ru_1), .timeout(to_1), .err(err_1),
        .err_code(code_1), .clause_count(cc_1));

    typedef struct {
        int rdy; int cmd; int a; int b; int c; int done;
        int rs; int ru; int to; int err; int code; int cc;
    } out_t;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    function automatic int p_nv(input int i);  return (i == 0) ? 128 : 64;  endfunction
    function automatic int p_mc(input int i);  return (i == 0) ? 256 : 2;   endfunction
    function automatic int p_to(input int i);  return (i == 0) ? 40 : 20;   endfunction

    function automatic out_t obs(input int i);
        out_t o;
        if (i == 0) begin
            o.rdy = int'(rdy_0); o.cmd = int'(cmd_0); o.a = int'(a_0); o.b = int'(b_0); o.c = int'(c_0);
            o.done = int'(done_0); o.rs = int'(rs_0); o.ru = int'(ru_0); o.to = int'(to_0);
            o.err = int'(err_0); o.code = int'(code_0); o.cc = int'(cc_0);
        end else begin
            o.rdy = int'(rdy_1); o.cmd = int'(cmd_1); o.a = int'(a_1); o.b = int'(b_1); o.c = int'(c_1);
            o.done = int'(done_1); o.rs = int'(rs_1); o.ru = int'(ru_1); o.to = int'(to_1);
            o.err = int'(err_1); o.code = int'(code_1); o.cc = int'(cc_1);
        end
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // mode: 0 taking bytes, 1 strobe showing, 2 awaiting result, 3 dead
    int m_mode [2];
    int m_op [2];
    int m_inclause [2];
    int m_nlit [2];
    int m_lit [2][3];
    int m_wait [2];
    int e_cmd [2], e_a [2], e_b [2], e_c [2], e_done [2];
    int e_rs [2], e_ru [2], e_to [2], e_err [2], e_code [2], e_cc [2];

    task automatic m_die(input int i, input int c);
        if (e_err[i] == 0) e_code[i] = c;
        e_err[i] = 1; m_mode[i] = 3; m_inclause[i] = 0; m_nlit[i] = 0;
    endtask

    task automatic m_fire(input int i, input int op);
        e_cmd[i] = op; m_op[i] = op; m_inclause[i] = 0; m_mode[i] = 1;
        if (op == 2) begin
            e_a[i] = m_lit[i][0]; e_b[i] = m_lit[i][1]; e_c[i] = m_lit[i][2];
            e_cc[i] = e_cc[i] + 1;
        end else begin
            e_a[i] = 0; e_b[i] = 0; e_c[i] = 0;
        end
        if (op == 0) e_cc[i] = 0;
        if (op == 4) begin e_rs[i] = 0; e_ru[i] = 0; e_to[i] = 0; end
    endtask

    task automatic m_step(input int i);
        int bv;
        if (rst_s[i]) begin
            m_mode[i] = 0; m_op[i] = 0; m_inclause[i] = 0; m_nlit[i] = 0; m_wait[i] = 0;
            e_cmd[i] = 255; e_a[i] = 0; e_b[i] = 0; e_c[i] = 0; e_done[i] = 0;
            e_rs[i] = 0; e_ru[i] = 0; e_to[i] = 0; e_err[i] = 0; e_code[i] = 0; e_cc[i] = 0;
        end else begin
            e_done[i] = 0;
            e_cmd[i]  = 255;
            bv = int'(in_data_s[i]);
            if (m_mode[i] == 0) begin
                if (in_valid_s[i]) begin
                    if (m_inclause[i] == 0) begin
                        if (bv == 0 || bv == 1 || bv == 3 || bv == 4) m_fire(i, bv);
                        else if (bv == 2) begin
                            if (e_cc[i] < p_mc(i)) begin m_inclause[i] = 1; m_nlit[i] = 0; end
                            else m_die(i, 3);
                        end else m_die(i, 1);
                    end else if ((bv % 128) >= p_nv(i)) begin
                        m_die(i, 2);
                    end else begin
                        m_lit[i][m_nlit[i]] = bv;
                        m_nlit[i] = m_nlit[i] + 1;
                        if (m_nlit[i] == 3) m_fire(i, 2);
                    end
                end
            end else if (m_mode[i] == 1) begin
                if (m_op[i] == 4) begin m_mode[i] = 2; m_wait[i] = 0; end
                else m_mode[i] = 0;
            end else if (m_mode[i] == 2) begin
                m_wait[i] = m_wait[i] + 1;
                if (sat_s[i] && !unsat_s[i]) begin e_rs[i] = 1; e_done[i] = 1; m_mode[i] = 0; end
                else if (unsat_s[i] && !sat_s[i]) begin e_ru[i] = 1; e_done[i] = 1; m_mode[i] = 0; end
                else if (sat_s[i] && unsat_s[i]) m_die(i, 3);
                else if (m_wait[i] >= p_to(i)) begin e_to[i] = 1; e_done[i] = 1; m_mode[i] = 0; end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) m_step(i);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        out_t o;
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                o = obs(i);
                chk($sformatf("u%0d.in_ready", i), o.rdy, (m_mode[i] == 0) ? 1 : 0);
                chk($sformatf("u%0d.cmd", i), o.cmd, e_cmd[i]);
                chk($sformatf("u%0d.bus_a", i), o.a, e_a[i]);
                chk($sformatf("u%0d.bus_b", i), o.b, e_b[i]);
                chk($sformatf("u%0d.bus_c", i), o.c, e_c[i]);
                chk($sformatf("u%0d.done", i), o.done, e_done[i]);
                chk($sformatf("u%0d.result_sat", i), o.rs, e_rs[i]);
                chk($sformatf("u%0d.result_unsat", i), o.ru, e_ru[i]);
                chk($sformatf("u%0d.timeout", i), o.to, e_to[i]);
                chk($sformatf("u%0d.err", i), o.err, e_err[i]);
                chk($sformatf("u%0d.err_code", i), o.code, e_code[i]);
                chk($sformatf("u%0d.clause_count", i), o.cc, e_cc[i]);
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+2) ----------------
    task automatic sync();
        @(posedge clk); #2;
    endtask

    task automatic send(input int i, input logic [7:0] b, output bit acc);
        out_t o;
        acc = 1'b0;
        in_data_s[i]  = b;
        in_valid_s[i] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            o = obs(i);
            if (o.rdy == 1) acc = 1'b1;
            @(posedge clk); #2;
            if (acc) break;
        end
        in_valid_s[i] = 1'b0;
    endtask

    task automatic send_ok(input int i, input logic [7:0] b);
        bit acc;
        send(i, b, acc);
        chk($sformatf("u%0d.accept_%02h", i, b), int'(acc), 1);
    endtask

    task automatic do_rst(input int i);
        rst_s[i] = 1'b1;
        sync();
        rst_s[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int lim, output int cyc);
        out_t o;
        cyc = 0;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            o = obs(i);
            if (o.done == 1) begin cyc = k; break; end
        end
        if (cyc == 0) chk($sformatf("u%0d.done_wait_expired", i), 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        out_t o;
        bit   acc;
        int   cyc;
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; in_valid_s[i] = 1'b0; in_data_s[i] = 8'h00;
            sat_s[i] = 1'b0; unsat_s[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            o = obs(i);
            chk("rst.cmd", o.cmd, 255); chk("rst.in_ready", o.rdy, 1);
            chk("rst.cc", o.cc, 0);     chk("rst.err", o.err, 0);
        end
        sync();

        // T1: clause 02 05 86 7F
        send_ok(0, 8'h02); send_ok(0, 8'h05); send_ok(0, 8'h86); send_ok(0, 8'h7F);
        @(negedge clk); o = obs(0);
        chk("t1.cmd", o.cmd, 2); chk("t1.bus_a", o.a, 5); chk("t1.bus_b", o.b, 134);
        chk("t1.bus_c", o.c, 127); chk("t1.cc", o.cc, 1); chk("t1.rdy_low", o.rdy, 0);
        @(negedge clk); o = obs(0);
        chk("t1.cmd_nop", o.cmd, 255); chk("t1.rdy_back", o.rdy, 1); chk("t1.bus_hold", o.a, 5);
        sync();

        // T2: walk, sat from 10 cycles after the strobe
        send_ok(0, 8'h04);
        @(negedge clk); o = obs(0);
        chk("t2.cmd", o.cmd, 4);
        repeat (10) sync();
        sat_s[0] = 1'b1;
        wait_done(0, 60, cyc);
        o = obs(0);
        chk("t2.rs", o.rs, 1); chk("t2.to", o.to, 0); chk("t2.ru", o.ru, 0); chk("t2.rdy", o.rdy, 1);
        @(negedge clk); o = obs(0);
        chk("t2.done_once", o.done, 0);
        sync();
        sat_s[0] = 1'b0;

        // Walk with unsat already present on the first waiting cycle
        send_ok(0, 8'h04);
        unsat_s[0] = 1'b1;
        wait_done(0, 10, cyc);
        o = obs(0);
        chk("t2b.latency", cyc, 3); chk("t2b.ru", o.ru, 1); chk("t2b.rs_cleared", o.rs, 0);
        sync();
        unsat_s[0] = 1'b0;

        // Walk with sat and unsat together -> error 3
        send_ok(0, 8'h04);
        sat_s[0] = 1'b1; unsat_s[0] = 1'b1;
        repeat (3) @(negedge clk);
        o = obs(0);
        chk("t2c.err", o.err, 1); chk("t2c.code", o.code, 3); chk("t2c.rdy", o.rdy, 0);
        sync();
        sat_s[0] = 1'b0; unsat_s[0] = 1'b0;
        do_rst(0);

        // T6: bad opcode, then reset discarding a partial clause
        send(0, 8'h09, acc);
        @(negedge clk); o = obs(0);
        chk("t6.err", o.err, 1); chk("t6.code", o.code, 1); chk("t6.rdy", o.rdy, 0);
        sync();
        do_rst(0);
        send_ok(0, 8'h02); send_ok(0, 8'h05);
        do_rst(0);
        send_ok(0, 8'h02); send_ok(0, 8'h01); send_ok(0, 8'h02); send_ok(0, 8'h03);
        @(negedge clk); o = obs(0);
        chk("t6.cmd", o.cmd, 2); chk("t6.bus_a", o.a, 1); chk("t6.bus_b", o.b, 2);
        chk("t6.bus_c", o.c, 3); chk("t6.cc", o.cc, 1); chk("t6.err_cleared", o.err, 0);
        sync();

        // T3: walk timeout on the small instance (20 waiting cycles)
        send_ok(1, 8'h04);
        wait_done(1, 40, cyc);
        o = obs(1);
        chk("t3.latency", cyc, 22); chk("t3.to", o.to, 1); chk("t3.rs", o.rs, 0);
        chk("t3.ru", o.ru, 0); chk("t3.rdy", o.rdy, 1);
        sync();

        // T5: capacity overflow, then RST_MODEL after reset
        for (int n = 0; n < 2; n++) begin
            send_ok(1, 8'h02); send_ok(1, 8'h01); send_ok(1, 8'h02); send_ok(1, 8'h03);
        end
        send_ok(1, 8'h02);
        @(negedge clk); o = obs(1);
        chk("t5.err", o.err, 1); chk("t5.code", o.code, 3); chk("t5.cc", o.cc, 2); chk("t5.rdy", o.rdy, 0);
        sync();
        do_rst(1);
        send_ok(1, 8'h02); send_ok(1, 8'h11); send_ok(1, 8'h92); send_ok(1, 8'h3F);
        @(negedge clk); o = obs(1);
        chk("t5.cmd_clause", o.cmd, 2); chk("t5.cc1", o.cc, 1); chk("t5.bus_b", o.b, 146);
        sync();
        send_ok(1, 8'h00);
        @(negedge clk); o = obs(1);
        chk("t5.cmd_rst_model", o.cmd, 0); chk("t5.cc0", o.cc, 0); chk("t5.bus_zero", o.a, 0);
        sync();

        // T4: variable out of range on the 64-variable instance
        do_rst(1);
        send_ok(1, 8'h02); send_ok(1, 8'h05); send_ok(1, 8'hC0);
        @(negedge clk); o = obs(1);
        chk("t4.err", o.err, 1); chk("t4.code", o.code, 2); chk("t4.rdy", o.rdy, 0); chk("t4.cmd", o.cmd, 255);
        sync();
        send(1, 8'h01, acc);
        chk("t4.not_accepted", int'(acc), 0);
        @(negedge clk); o = obs(1);
        chk("t4.code_sticky", o.code, 2); chk("t4.cc", o.cc, 0);
        sync();

        repeat (3) sync();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
